// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : N-port arbiter funnelling single-outstanding requests to one memory.
// Revision: 1.0
// ============================================================================

module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int                 c_IDX_W    = $clog2(NUM_PORTS);
    localparam int                 c_STRB_W   = DATA_W / 8;
    localparam logic [15:0]        c_TIMEOUT  = 16'(TIMEOUT);
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rst_meta;
    logic                   r_rst_sync;
    logic [c_IDX_W-1:0]     r_last_grant;
    logic [c_IDX_W-1:0]     r_grant;
    logic [c_IDX_W-1:0]     w_winner;
    logic [NUM_PORTS-1:0]   w_grant_oh;
    logic [15:0]            r_wait_cnt;
    logic                   w_any;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic                   r_mem_we;
    logic [c_STRB_W-1:0]    r_mem_wstrb;
    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;

    // Reset asserts at once but leaves the core only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_any = |req_valid;

    generate
        if (RR_MODE != 0) begin : g_rr
            // Walk from farthest to nearest so the port right after last_grant wins.
            always_comb begin
                w_winner = r_last_grant;
                for (int k = NUM_PORTS; k >= 1; k--) begin
                    if (req_valid[(int'(r_last_grant) + k) % NUM_PORTS])
                        w_winner = c_IDX_W'((int'(r_last_grant) + k) % NUM_PORTS);
                end
            end
        end else begin : g_fixed
            always_comb begin
                w_winner = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (req_valid[i])
                        w_winner = c_IDX_W'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        req_ready = '0;
        if (r_rst_sync && (r_state == S_IDLE) && w_any)
            req_ready[w_winner] = 1'b1;
    end

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)         w_state_nxt = S_ISSUE;
            S_ISSUE: if (mem_req_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_rsp_valid || (r_wait_cnt == c_TIMEOUT))
                         w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_LAST_RST;
            r_grant      <= '0;
            r_wait_cnt   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= '0;

            if ((r_state == S_IDLE) && w_any) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_mem_addr   <= req_addr[int'(w_winner) * ADDR_W +: ADDR_W];
                r_mem_wdata  <= req_wdata[int'(w_winner) * DATA_W +: DATA_W];
                r_mem_we     <= req_we[w_winner];
                r_mem_wstrb  <= req_wstrb[int'(w_winner) * c_STRB_W +: c_STRB_W];
            end

            if ((r_state == S_ISSUE) && mem_req_ready)
                r_wait_cnt <= '0;
            else if ((r_state == S_WAIT) && !mem_rsp_valid && (r_wait_cnt != 16'hFFFF))
                r_wait_cnt <= r_wait_cnt + 16'd1;

            // A real response wins over a timeout landing in the same cycle.
            if (r_state == S_WAIT) begin
                if (mem_rsp_valid) begin
                    r_rsp_valid <= w_grant_oh;
                    r_rsp_rdata <= mem_rdata;
                    r_rsp_err   <= 1'b0;
                end else if (r_wait_cnt == c_TIMEOUT) begin
                    r_rsp_valid <= w_grant_oh;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign mem_req_valid = (r_state == S_ISSUE);
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = r_mem_we;
    assign mem_wstrb     = r_mem_wstrb;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter (round-robin and fixed priority).
// Revision: 1.0
// ============================================================================

module tb_mem_arbiter;

    localparam int NP = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NP-1:0]   req_valid, req_we, req_ready, rsp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*SW-1:0] req_wstrb;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            rsp_err, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [AW-1:0]   mem_addr;
    logic [SW-1:0]   mem_wstrb;
    logic            auto_mem, man_ready, man_rsp, auto_rsp;

    assign mem_req_ready = auto_mem ? 1'b1 : man_ready;
    assign mem_rsp_valid = auto_mem ? auto_rsp : man_rsp;

    // Zero-wait memory: answers the cycle after each accepted request.
    always @(posedge clk or negedge rst) begin
        if (!rst) auto_rsp <= 1'b0;
        else      auto_rsp <= auto_mem && mem_req_valid && mem_req_ready;
    end

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    // Fixed-priority instance with both ports always requesting.
    logic [NP-1:0] fp_req_valid, fp_req_ready, fp_rsp_valid;
    logic [DW-1:0] fp_rsp_rdata, fp_mem_wdata;
    logic          fp_rsp_err, fp_mem_req_valid, fp_mem_we, fp_mem_rsp, fp_one;
    logic [AW-1:0] fp_mem_addr;
    logic [SW-1:0] fp_mem_wstrb;
    assign fp_req_valid = 2'b11;
    assign fp_one       = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) fp_mem_rsp <= 1'b0;
        else      fp_mem_rsp <= fp_mem_req_valid;
    end

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fp (
        .clk(clk), .rst(rst), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_wstrb(req_wstrb),
        .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err),
        .mem_req_valid(fp_mem_req_valid), .mem_req_ready(fp_one),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we), .mem_wstrb(fp_mem_wstrb),
        .mem_rsp_valid(fp_mem_rsp), .mem_rdata(mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] v, input int last);
        for (int k = 1; k <= NP; k++)
            if (v[(last + k) % NP]) return (last + k) % NP;
        return 0;
    endfunction

    // Transaction-level model: one request in flight, response deadline by cycle number.
    int            cyc = 0;
    int            m_rcnt = 2;
    int            m_last = NP - 1;
    int            m_owner = 0;
    int            m_deadline = 0;
    bit            m_busy = 1'b0;
    bit            m_issued = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_we = 1'b0;
    logic [SW-1:0] m_wstrb = '0;
    logic [NP-1:0] e_rsp_valid = '0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (rst) cyc <= cyc + 1;
        if (!rst || m_rcnt > 0) begin
            m_rcnt      <= !rst ? 2 : m_rcnt - 1;
            m_last      <= NP - 1;
            m_busy      <= 1'b0;
            m_issued    <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_we        <= 1'b0;
            m_wstrb     <= '0;
            e_rsp_valid <= '0;
            e_rdata     <= '0;
            e_err       <= 1'b0;
        end else begin
            e_rsp_valid <= '0;
            if (!m_busy) begin
                if (|req_valid) begin
                    m_busy   <= 1'b1;
                    m_issued <= 1'b0;
                    m_owner  <= rr_pick(req_valid, m_last);
                    m_last   <= rr_pick(req_valid, m_last);
                    m_addr   <= req_addr[rr_pick(req_valid, m_last) * AW +: AW];
                    m_wdata  <= req_wdata[rr_pick(req_valid, m_last) * DW +: DW];
                    m_we     <= req_we[rr_pick(req_valid, m_last)];
                    m_wstrb  <= req_wstrb[rr_pick(req_valid, m_last) * SW +: SW];
                end
            end else if (!m_issued) begin
                if (mem_req_ready) begin
                    m_issued   <= 1'b1;
                    m_deadline <= cyc + 1 + TO;
                end
            end else if (mem_rsp_valid) begin
                m_busy      <= 1'b0;
                e_rsp_valid <= NP'(1) << m_owner;
                e_rdata     <= mem_rdata;
                e_err       <= 1'b0;
            end else if (cyc == m_deadline) begin
                m_busy      <= 1'b0;
                e_rsp_valid <= NP'(1) << m_owner;
                e_rdata     <= '0;
                e_err       <= 1'b1;
            end
        end
    end

    int fp_g0 = 0;
    int fp_g1 = 0;

    always @(negedge clk) begin
        logic [NP-1:0] e_ready;
        e_ready = '0;
        if (rst && m_rcnt == 0 && !m_busy && |req_valid)
            e_ready[rr_pick(req_valid, m_last)] = 1'b1;
        chk("req_ready", req_ready, e_ready);
        chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_we", mem_we, m_we);
        chk("mem_wstrb", mem_wstrb, m_wstrb);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", rsp_err, e_err);
        if (|fp_req_ready) begin
            chk("fp_grant", fp_req_ready, 2'b01);
            if (fp_req_ready[0]) fp_g0 <= fp_g0 + 1;
            if (fp_req_ready[1]) fp_g1 <= fp_g1 + 1;
        end
        if (|fp_rsp_valid) chk("fp_rsp_port", fp_rsp_valid, 2'b01);
    end

    task automatic do_req(input logic [NP-1:0] mask, output int port, output int acc);
        bit found;
        found = 1'b0;
        port  = -1;
        acc   = 0;
        req_valid = mask;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                found = 1'b1;
                port  = req_ready[1] ? 1 : 0;
                acc   = cyc;
            end
        end
        chk("req_accept_timeout", found, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_rsp(output int rc);
        bit found;
        found = 1'b0;
        rc    = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                found = 1'b1;
                rc    = cyc;
            end
        end
        chk("rsp_wait_timeout", found, 1'b1);
    endtask

    int port_g, acc_c, rsp_c, n_acc, n_rsp;
    int g_port[8];
    int g_cyc[8];
    int r_cyc[8];

    initial begin
        rst = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        auto_mem = 1'b0; man_ready = 1'b0; man_rsp = 1'b0; mem_rdata = '0;

        // Reset: nothing granted even with requests present.
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        req_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Port 0 read, zero-wait memory, minimum latency and data hold.
        req_addr[0 +: AW] = 64'h40;
        auto_mem  = 1'b1;
        mem_rdata = 64'hDEADBEEF_CAFEF00D;
        do_req(2'b01, port_g, acc_c);
        chk("t043_grant", port_g, 0);
        wait_rsp(rsp_c);
        chk("t043_latency", rsp_c - acc_c, 3);
        chk("t043_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        mem_rdata = 64'h1111_2222_3333_4444;
        repeat (5) @(negedge clk);
        chk("t043_hold", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

        // Port 1 write with memory stalling for four cycles.
        @(posedge clk); #1;
        auto_mem = 1'b0; man_ready = 1'b0;
        req_addr[AW +: AW]  = 64'h100;
        req_wdata[DW +: DW] = 64'hA5A5_0000_1234_5678;
        req_we[1]           = 1'b1;
        req_wstrb[SW +: SW] = 8'h0F;
        do_req(2'b10, port_g, acc_c);
        chk("t040_grant", port_g, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t040_valid", mem_req_valid, 1'b1);
            chk("t040_addr", mem_addr, 64'h100);
            chk("t040_wdata", mem_wdata, 64'hA5A5_0000_1234_5678);
            chk("t040_we", mem_we, 1'b1);
            chk("t040_wstrb", mem_wstrb, 8'h0F);
        end
        @(posedge clk); #1 man_ready = 1'b1;
        @(posedge clk); #1 man_ready = 1'b0; man_rsp = 1'b1; mem_rdata = 64'h0BAD_F00D;
        @(negedge clk);
        chk("t040_no_early_rsp", rsp_valid, 2'b00);
        @(posedge clk); #1 man_rsp = 1'b0;
        @(negedge clk);
        chk("t040_rsp", rsp_valid, 2'b10);
        chk("t040_rdata", rsp_rdata, 64'h0BAD_F00D);
        chk("t040_mem_hold_valid", mem_req_valid, 1'b0);
        chk("t040_mem_hold_addr", mem_addr, 64'h100);

        // Both ports requesting continuously: round-robin alternation.
        @(posedge clk); #1;
        auto_mem = 1'b1;
        req_we   = '0;
        req_addr = {64'h300, 64'h200};
        req_valid = 2'b11;
        n_acc = 0; n_rsp = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (|req_ready && n_acc < 8) begin
                g_port[n_acc] = req_ready[1] ? 1 : 0;
                g_cyc[n_acc]  = cyc;
                n_acc++;
            end
            if (|rsp_valid && n_rsp < 8) begin
                r_cyc[n_rsp] = cyc;
                n_rsp++;
            end
            if (i == 14) begin
                @(posedge clk); #1 req_valid = '0;
            end
        end
        chk("t038_accepts", n_acc, 5);
        chk("t038_responses", n_rsp, 5);
        chk("t038_g0", g_port[0], 0);
        chk("t038_g1", g_port[1], 1);
        chk("t038_g2", g_port[2], 0);
        chk("t038_g3", g_port[3], 1);
        chk("t038_spacing", g_cyc[1] - g_cyc[0], 3);
        for (int k = 0; k < 4; k++)
            chk("t038_latency", r_cyc[k] - g_cyc[k], 3);

        // Timeout with a response in the handshake cycle and a late one after.
        @(posedge clk); #1;
        auto_mem = 1'b0; man_ready = 1'b1; man_rsp = 1'b0;
        do_req(2'b01, port_g, acc_c);
        man_rsp = 1'b1;
        @(posedge clk); #1 man_rsp = 1'b0;
        wait_rsp(rsp_c);
        chk("t041_latency", rsp_c - acc_c, 6);
        chk("t041_valid", rsp_valid, 2'b01);
        chk("t041_err", rsp_err, 1'b1);
        chk("t041_rdata", rsp_rdata, 64'h0);
        @(posedge clk); #1 man_rsp = 1'b1; mem_rdata = 64'h5555;
        @(posedge clk); #1 man_rsp = 1'b0;
        @(negedge clk);
        chk("t041_late_ignored", rsp_valid, 2'b00);
        chk("t041_err_hold", rsp_err, 1'b1);

        // Reset while waiting: outputs clear at once, nothing is answered.
        @(posedge clk); #1;
        man_ready = 1'b1;
        do_req(2'b01, port_g, acc_c);
        @(posedge clk); #2 rst = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t042_rsp_valid", rsp_valid, 2'b00);
        chk("t042_rsp_err", rsp_err, 1'b0);
        chk("t042_rsp_rdata", rsp_rdata, 64'h0);
        chk("t042_mem_req_valid", mem_req_valid, 1'b0);
        chk("t042_mem_addr", mem_addr, 64'h0);
        chk("t042_req_ready", req_ready, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; auto_mem = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t042_no_rsp", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;
        do_req(2'b10, port_g, acc_c);
        chk("t042_p1_grant", port_g, 1);
        wait_rsp(rsp_c);
        chk("t042_p1_rsp", rsp_valid, 2'b10);

        // Reset during ISSUE after a port 0 grant: arbitration restarts at port 0.
        @(posedge clk); #1;
        auto_mem = 1'b0; man_ready = 1'b0;
        do_req(2'b01, port_g, acc_c);
        #1 rst = 1'b0;
        #1 chk("t036_issue_abandon", mem_req_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; auto_mem = 1'b1;
        repeat (3) @(posedge clk); #1;
        do_req(2'b11, port_g, acc_c);
        chk("t036_first_grant", port_g, 0);
        wait_rsp(rsp_c);
        chk("t036_rsp", rsp_valid, 2'b01);
        repeat (3) @(posedge clk);

        chk("t039_starve", fp_g1, 0);
        chk("t039_served", fp_g0 > 10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
